// File: rtl/gear_pkg.sv
// Shared definitions for the GeAr correction controller: state encoding and
// elaboration-time helpers for deriving sub-adder count and counter width.
package gear_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, CORR, DONE} state_t;

    function automatic int gear_nsub(input int size, input int r, input int p);
        return (size - r - p) / r + 1;
    endfunction

    // Never returns less than 1 so a single-sub-adder build still has a legal port width.
    function automatic int gear_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gear.sv
// GeAr(SIZE,R,P) approximate adder: NSUB overlapping L-bit windows, each
// contributing its top R bits; only sub-adder 0 sees the carry in.
module gear
    import gear_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int R    = 2,
    parameter int P    = 6
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    localparam int L    = R + P;
    localparam int NSUB = gear_nsub(SIZE, R, P);

    for (genvar i = 0; i < NSUB; i++) begin : g_sub
        localparam int LO = i * R;
        localparam int HI = i * R + L - 1;
        logic [L:0] win;

        if (i == 0) begin : g_first
            assign win      = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]} + {{L{1'b0}}, cin};
            assign sum[HI:0] = win[L-1:0];
        end else begin : g_rest
            // Prediction bits only feed the window carry; they are not part of the sum.
            logic [P-1:0] pred_unused;
            assign win              = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]};
            assign sum[HI:LO+P]     = win[L-1:P];
            assign pred_unused      = win[P-1:0];
        end

        if (i == NSUB - 1) begin : g_cout
            assign cout = win[L];
        end else begin : g_nocout
            logic c_unused;
            assign c_unused = win[L];
        end
    end

endmodule

// File: rtl/gear_err_detect.sv
// Exact reference sum plus per-window error flags: a window is wrong exactly
// when a real carry enters it and its prediction bits all propagate.
module gear_err_detect
    import gear_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int R    = 2,
    parameter int P    = 6,
    parameter int NSUB = gear_nsub(SIZE, R, P)
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] exact_sum,
    output logic            exact_cout,
    output logic [NSUB-1:0] err
);

    logic [SIZE:0] full;

    assign full       = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
    assign exact_sum  = full[SIZE-1:0];
    assign exact_cout = full[SIZE];
    assign err[0]     = 1'b0;

    // Carry into bit k is recovered as sum ^ a ^ b at that bit.
    for (genvar i = 1; i < NSUB; i++) begin : g_err
        localparam int LO = i * R;
        assign err[i] = (full[LO] ^ a[LO] ^ b[LO]) & (&(a[LO+P-1:LO] ^ b[LO+P-1:LO]));
    end

endmodule

// File: rtl/gear_corr_ctrl.sv
// Handshaked GeAr wrapper that registers the approximate sum, then repairs the
// lowest erroneous window once per cycle until clean or out of budget.
module gear_corr_ctrl
    import gear_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int R    = 2,
    parameter int P    = 6,
    parameter int NSUB = gear_nsub(SIZE, R, P),
    parameter int CW   = gear_clog2(NSUB)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            CIN,
    input  logic [CW-1:0]   MAXCORR,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SIZE-1:0] SUM,
    output logic            COUT,
    output logic            ERR_LEFT,
    output logic [CW-1:0]   NCORR
);

    state_t            state;
    logic [SIZE-1:0]   a_r;
    logic [SIZE-1:0]   b_r;
    logic              cin_r;
    logic [CW-1:0]     budget;
    logic [NSUB-1:0]   errv;

    logic [SIZE-1:0]   approx_sum;
    logic              approx_cout;
    logic [SIZE-1:0]   exact_sum;
    logic              exact_cout;
    logic [NSUB-1:0]   err;

    logic [NSUB-1:0]   low_oh;
    logic [NSUB-1:0]   errv_nx;
    logic [SIZE-1:0]   fix_mask;
    logic [SIZE-1:0]   sum_fix;
    logic [CW-1:0]     ncorr_nx;

    function automatic logic [CW-1:0] sat_budget(input logic [CW-1:0] m);
        return (int'(m) > NSUB - 1) ? CW'(NSUB - 1) : m;
    endfunction

    gear #(.SIZE(SIZE), .R(R), .P(P)) u_gear (
        .a    (a_r),
        .b    (b_r),
        .cin  (cin_r),
        .sum  (approx_sum),
        .cout (approx_cout)
    );

    gear_err_detect #(.SIZE(SIZE), .R(R), .P(P), .NSUB(NSUB)) u_err (
        .a          (a_r),
        .b          (b_r),
        .cin        (cin_r),
        .exact_sum  (exact_sum),
        .exact_cout (exact_cout),
        .err        (err)
    );

    // Isolate the lowest pending error and splice in the exact bits for its window.
    assign low_oh   = errv & (~errv + NSUB'(1));
    assign errv_nx  = errv & ~low_oh;
    assign ncorr_nx = NCORR + CW'(1);
    assign sum_fix  = (SUM & ~fix_mask) | (exact_sum & fix_mask);

    always_comb begin
        fix_mask = '0;
        for (int i = 0; i < NSUB; i++) begin
            if (low_oh[i]) fix_mask[i*R+P +: R] = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && IN_VALID && IN_READY) begin
            a_r   <= A;
            b_r   <= B;
            cin_r <= CIN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            SUM       <= '0;
            COUT      <= 1'b0;
            ERR_LEFT  <= 1'b0;
            NCORR     <= '0;
            errv      <= '0;
            budget    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        budget   <= sat_budget(MAXCORR);
                        IN_READY <= 1'b0;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    SUM   <= approx_sum;
                    COUT  <= approx_cout;
                    errv  <= err;
                    NCORR <= '0;
                    if (err == '0 || budget == '0) begin
                        ERR_LEFT  <= |err;
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CORR;
                    end
                end
                CORR: begin
                    SUM   <= sum_fix;
                    errv  <= errv_nx;
                    NCORR <= ncorr_nx;
                    if (low_oh[NSUB-1]) COUT <= exact_cout;
                    if (errv_nx == '0 || ncorr_nx == budget) begin
                        ERR_LEFT  <= |errv_nx;
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
